// File: rtl/seq_multiplier.sv
// ============================================================================
// seq_multiplier : radix-2 shift-add multiplier, signed/unsigned per op,
//                  valid/ready on both sides. Option: MULT_EARLY_DONE_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [CW-1:0]      count;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] acc_fin;
  logic [WIDTH-1:0]   mplier_shr;
  logic               last_step;
  logic               accept;
  logic               deliver;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned.
  assign abs_a      = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b      = (is_signed && b[WIDTH-1]) ? -b : b;
  assign acc_sum    = acc + (mplier[0] ? mcand : '0);
  assign acc_fin    = neg ? -acc_sum : acc_sum;
  assign mplier_shr = mplier >> 1;

`ifdef MULT_EARLY_DONE_EN
  assign last_step  = (mplier_shr == '0) || (count == CW'(WIDTH - 1));
`else
  assign last_step  = (count == CW'(WIDTH - 1));
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (deliver)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      count  <= '0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_shr;
          count  <= count + CW'(1);
          if (last_step) begin
            p <= acc_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
